// File: rtl/switch_debounce_multi_pkg.sv
// Shared constants for the multi-channel push-button front end:
// LED behaviour encodings and the default debounce time for the 12 MHz board clock.
package switch_debounce_multi_pkg;

  localparam int LED_FOLLOW = 0;
  localparam int LED_TOGGLE = 1;

  // 5 ms at 12 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 60000;
  localparam int DEFAULT_CNT_W           = 17;

endpackage

// File: rtl/switch_debounce_multi_pin_in_pullup.sv
// One iCE40 input pad with the internal pull-up enabled, unregistered input path.
// Outside synthesis the pad is passed straight through so the design simulates without vendor cells.
module pin_in_pullup (
  input  logic PACKAGE_PIN,
  output logic D_IN_0
);

`ifdef SYNTHESIS
  // PIN_TYPE: no output driver, plain (non-registered) input
  SB_IO #(
    .PIN_TYPE (6'b0000_01),
    .PULLUP   (1'b1)
  ) u_sb_io (
    .PACKAGE_PIN (PACKAGE_PIN),
    .D_IN_0      (D_IN_0)
  );
`else
  assign D_IN_0 = PACKAGE_PIN;
`endif

endmodule

// File: rtl/switch_debounce_multi.sv
// N-channel push-button front end: pull-up pad, 2-flop synchroniser, counter debounce,
// one-cycle press/release strobes and an LED that follows or toggles with the button.
module switch_debounce_multi
  import switch_debounce_multi_pkg::*;
#(
  parameter int N_CH            = 2,
  parameter int CNT_W           = DEFAULT_CNT_W,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int ACTIVE_LOW      = 1,
  parameter int LED_MODE        = LED_FOLLOW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sw_pad,
  output logic [N_CH-1:0] pressed,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_stb,  // "release" is a reserved word
  output logic [N_CH-1:0] led
);

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             PAD_INVERT  = (ACTIVE_LOW != 0);
  localparam bit               TOGGLE_MODE = (LED_MODE == LED_TOGGLE);

  if (N_CH < 1 || N_CH > 16) begin : gen_bad_n_ch
    $error("switch_debounce_multi: N_CH must be in 1..16");
  end
  if (CNT_W < 2 || CNT_W > 31) begin : gen_bad_cnt_w
    $error("switch_debounce_multi: CNT_W must be in 2..31");
  end
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : gen_bad_debounce
    $error("switch_debounce_multi: DEBOUNCE_CYCLES must be in 2..2^CNT_W-1");
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : gen_ch
    logic             w_din;
    logic             w_p;
    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pressed;
    logic             r_press;
    logic             r_release;
    logic             r_led;

    pin_in_pullup u_pin (
      .PACKAGE_PIN (sw_pad[gi]),
      .D_IN_0      (w_din)
    );

    assign w_p = w_din ^ PAD_INVERT;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s1      <= 1'b0;
        r_s2      <= 1'b0;
        r_cnt     <= '0;
        r_pressed <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_led     <= 1'b0;
      end else begin
        r_s1      <= w_p;
        r_s2      <= r_s1;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        // Any return to the accepted level restarts the stability count
        if (r_s2 == r_pressed) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_cnt     <= '0;
          r_pressed <= r_s2;
          r_press   <= r_s2;
          r_release <= ~r_s2;
          if (TOGGLE_MODE) begin
            if (r_s2) r_led <= ~r_led;
          end else begin
            r_led <= r_s2;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign pressed[gi]     = r_pressed;
    assign press[gi]       = r_press;
    assign release_stb[gi] = r_release;
    assign led[gi]         = r_led;
  end

endmodule

// File: tb/tb_switch_debounce_multi.sv
// Directed bench: follow-mode, toggle-mode and active-high instances with DEBOUNCE_CYCLES=8.
module tb_switch_debounce_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] pad_f = 2'b11;
  logic [1:0] pad_t = 2'b11;
  logic [1:0] pad_h;

  logic [1:0] pressed_f, press_f, rel_f, led_f;
  logic [1:0] pressed_t, press_t, rel_t, led_t;
  logic [1:0] pressed_h, press_h, rel_h, led_h;

  int n_cmp = 0;
  int n_err = 0;

  assign pad_h = ~pad_f;

  always #5 clk = ~clk;

  switch_debounce_multi #(.N_CH(2), .CNT_W(4), .DEBOUNCE_CYCLES(8), .ACTIVE_LOW(1), .LED_MODE(0)) dut_f (
    .clk(clk), .rst(rst), .sw_pad(pad_f),
    .pressed(pressed_f), .press(press_f), .release_stb(rel_f), .led(led_f));

  switch_debounce_multi #(.N_CH(2), .CNT_W(4), .DEBOUNCE_CYCLES(8), .ACTIVE_LOW(1), .LED_MODE(1)) dut_t (
    .clk(clk), .rst(rst), .sw_pad(pad_t),
    .pressed(pressed_t), .press(press_t), .release_stb(rel_t), .led(led_t));

  switch_debounce_multi #(.N_CH(2), .CNT_W(4), .DEBOUNCE_CYCLES(8), .ACTIVE_LOW(0), .LED_MODE(0)) dut_h (
    .clk(clk), .rst(rst), .sw_pad(pad_h),
    .pressed(pressed_h), .press(press_h), .release_stb(rel_h), .led(led_h));

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic test_reset;
    logic [1:0] seen;
    rst = 1'b1;
    tick(3);
    chk("reset_pressed", pressed_f, 2'b00);
    chk("reset_led", led_f, 2'b00);
    chk("reset_strobes", press_f | rel_f, 2'b00);
    rst = 1'b0;
    seen = 2'b00;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      seen = seen | pressed_f | press_f | rel_f | led_f | pressed_t | led_t;
    end
    chk("idle_50_any_output", seen, 2'b00);
    $display("test_reset: idle outputs or-ed = %b", seen);
  endtask

  task automatic test_clean_step;
    pad_f[0] = 1'b0;
    tick(9);
    chk("step_pressed_edge9", pressed_f, 2'b00);
    chk("step_press_edge9", press_f, 2'b00);
    tick(1);
    chk("step_pressed_edge10", pressed_f, 2'b01);
    chk("step_press_edge10", press_f, 2'b01);
    chk("step_led_edge10", led_f, 2'b01);
    chk("step_ah_pressed", pressed_h, 2'b01);
    tick(1);
    chk("step_press_one_cycle", press_f, 2'b00);
    chk("step_pressed_held", pressed_f, 2'b01);
    $display("test_clean_step: pressed=%b led=%b", pressed_f, led_f);
    pad_f[0] = 1'b1;
    tick(9);
    chk("rel_pressed_edge9", pressed_f, 2'b01);
    tick(1);
    chk("rel_pressed_edge10", pressed_f, 2'b00);
    chk("rel_strobe_edge10", rel_f, 2'b01);
    chk("rel_no_press", press_f, 2'b00);
    chk("rel_led_off", led_f, 2'b00);
    tick(1);
    chk("rel_strobe_one_cycle", rel_f, 2'b00);
    $display("test_clean_step: release done pressed=%b", pressed_f);
  endtask

  task automatic test_glitch;
    logic [1:0] seen;
    seen = 2'b00;
    pad_f[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(1); seen = seen | pressed_f | press_f; end
    pad_f[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin tick(1); seen = seen | pressed_f | press_f; end
    pad_f[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(1); seen = seen | pressed_f | press_f; end
    pad_f[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin tick(1); seen = seen | pressed_f | press_f; end
    chk("glitch_no_press", seen, 2'b00);
    // Counter must be back at zero: a clean step now takes the full latency again
    pad_f[0] = 1'b0;
    tick(9);
    chk("glitch_then_step_edge9", pressed_f, 2'b00);
    tick(1);
    chk("glitch_then_step_edge10", press_f, 2'b01);
    pad_f[0] = 1'b1;
    tick(12);
    chk("glitch_cleanup", pressed_f, 2'b00);
    $display("test_glitch: seen=%b", seen);
  endtask

  task automatic test_toggle;
    int n_press = 0;
    int n_rel = 0;
    logic [1:0] exp_led [3];
    exp_led[0] = 2'b10;
    exp_led[1] = 2'b00;
    exp_led[2] = 2'b10;
    for (int c = 0; c < 3; c++) begin
      pad_t[1] = 1'b0;
      for (int i = 0; i < 12; i++) begin
        tick(1);
        if (press_t[1]) n_press++;
        if (rel_t[1]) n_rel++;
      end
      chk("toggle_led_after_press", led_t, exp_led[c]);
      pad_t[1] = 1'b1;
      for (int i = 0; i < 12; i++) begin
        tick(1);
        if (press_t[1]) n_press++;
        if (rel_t[1]) n_rel++;
      end
      chk("toggle_led_after_release", led_t, exp_led[c]);
      $display("test_toggle: cycle %0d led=%b", c, led_t);
    end
    n_cmp++;
    if (n_press != 3 || n_rel != 3) begin
      n_err++;
      $display("FAIL toggle_strobe_count: got press=%0d release=%0d expected 3/3", n_press, n_rel);
    end
  endtask

  task automatic test_back_to_back;
    pad_f = 2'b00;
    tick(9);
    chk("both_press_edge9", press_f, 2'b00);
    tick(1);
    chk("both_press_edge10", press_f, 2'b11);
    chk("both_led", led_f, 2'b11);
    pad_f = 2'b11;
    tick(9);
    chk("both_rel_edge9", rel_f, 2'b00);
    tick(1);
    chk("both_rel_edge10", rel_f, 2'b11);
    chk("both_rel_no_press", press_f, 2'b00);
    $display("test_back_to_back: release=%b pressed=%b", rel_f, pressed_f);
    tick(2);
  endtask

  task automatic test_reset_mid_count;
    pad_f[1] = 1'b0;
    tick(12);
    chk("pre_rst_ch1_pressed", pressed_f, 2'b10);
    pad_f[0] = 1'b0;
    tick(7);  // ch0 count has reached 5
    rst = 1'b1;
    tick(1);
    chk("mid_rst_pressed", pressed_f, 2'b00);
    chk("mid_rst_led", led_f, 2'b00);
    chk("mid_rst_strobes", press_f | rel_f, 2'b00);
    chk("mid_rst_ah_pressed", pressed_h, 2'b00);
    rst = 1'b0;
    tick(9);
    chk("after_rst_edge9", pressed_f, 2'b00);
    chk("after_rst_ah_edge9", pressed_h, 2'b00);
    tick(1);
    chk("after_rst_press_edge10", press_f, 2'b11);
    chk("after_rst_pressed_edge10", pressed_f, 2'b11);
    chk("after_rst_ah_press_edge10", press_h, 2'b11);
    chk("after_rst_ah_led_edge10", led_h, 2'b11);
    $display("test_reset_mid_count: press=%b ah_press=%b", press_f, press_h);
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_glitch();
    test_toggle();
    test_back_to_back();
    test_reset_mid_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
